mmio_responder: RTL

- Responder for the core's data-memory request interface in the IO address region (addr[31:28] == IO_BASE).
- Serves loads and stores from the mem/wb stage against the UART TX/RX buffers, the cycle counter and the retired-instruction counter.
- Read data is registered and returned one cycle after the request, so the core's writeback mux selects it alongside data memory.
- The UART serializer/deserializer sits on the far side of the tx/rx ready/valid ports.

---
 rtl/io_pkg.sv | 25 ++
 rtl/mmio_responder_if.sv | 37 +++
 rtl/mmio_counters.sv | 42 ++++
 rtl/mmio_responder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the IO-region responder: region select, register offsets
// and store-size encodings used by the core's data-memory request port.
package io_pkg;

  localparam logic [3:0] IO_BASE   = 4'h8;
  localparam int         CNT_WIDTH = 32;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYC    = 8'h10;
  localparam logic [7:0] OFF_INST   = 8'h14;
  localparam logic [7:0] OFF_CRST   = 8'h18;

  localparam logic [1:0] SSEL_SB   = 2'd0;
  localparam logic [1:0] SSEL_SH   = 2'd1;
  localparam logic [1:0] SSEL_SW   = 2'd2;
  localparam logic [1:0] SSEL_NONE = 2'd3;

  // A store is real only when the size field is not the "none" encoding.
  function automatic logic is_store(input logic we, input logic [1:0] ssel);
    return we && (ssel != SSEL_NONE);
  endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// Request/response bus between the core's mem/wb stage and the IO responder,
// plus the byte-wide ready/valid links to the UART serializer/deserializer.
interface mmio_responder_if;

  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [1:0]  req_ssel;
  logic        req_re;
  logic [31:0] rdata;
  logic        rd_hit;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output req_addr, req_wdata, req_we, req_ssel, req_re,
    input  rdata, rd_hit,
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  req_addr, req_wdata, req_we, req_ssel, req_re,
    output rdata, rd_hit,
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/mmio_counters.sv
// Free-running cycle counter and retired-instruction counter; a clear wins over
// any increment on the same edge and both wrap silently.
module mmio_counters #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 retire,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] inst_cnt
);

  logic [CNT_WIDTH-1:0] cycle_cnt_reg, cycle_cnt_next;
  logic [CNT_WIDTH-1:0] inst_cnt_reg,  inst_cnt_next;

  always_comb begin
    cycle_cnt_next = cycle_cnt_reg + CNT_WIDTH'(1);
    inst_cnt_next  = inst_cnt_reg;
    if (retire) begin
      inst_cnt_next = inst_cnt_reg + CNT_WIDTH'(1);
    end
    if (clr) begin
      cycle_cnt_next = '0;
      inst_cnt_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_reg <= '0;
      inst_cnt_reg  <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_next;
      inst_cnt_reg  <= inst_cnt_next;
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
  assign inst_cnt  = inst_cnt_reg;

endmodule

// File: rtl/mmio_responder.sv
// IO-region responder: UART TX/RX byte buffers, cycle and retired-instruction
// counters, and a registered one-cycle-latency read port for the writeback mux.
module mmio_responder #(
  parameter logic [3:0] IO_BASE   = io_pkg::IO_BASE,
  parameter int         CNT_WIDTH = io_pkg::CNT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_retire,
  mmio_responder_if.slave bus
);

  import io_pkg::*;

  logic       hit;
  logic [7:0] off;
  logic       store_hit;
  logic       load_hit;

  logic [31:0] rdata_reg, rdata_next;
  logic        rd_hit_reg, rd_hit_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic        tx_valid_reg, tx_valid_next;
  logic [7:0]  rx_byte_reg, rx_byte_next;
  logic        rx_full_reg, rx_full_next;
  logic        rx_ready;
  logic        cnt_clr;

  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] inst_cnt;

  logic unused_bits;

  assign hit       = (bus.req_addr[31:28] == IO_BASE);
  assign off       = bus.req_addr[7:0];
  assign store_hit = hit && is_store(bus.req_we, bus.req_ssel);
  assign load_hit  = hit && bus.req_re;
  assign cnt_clr   = store_hit && (off == OFF_CRST);
  assign rx_ready  = !rx_full_reg && !rst;

  // Only the low byte of store data and the low byte of the offset are decoded.
  assign unused_bits = ^{bus.req_wdata[31:8], bus.req_addr[27:8]};

  mmio_counters #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_counters (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .retire    (inst_retire),
    .cycle_cnt (cycle_cnt),
    .inst_cnt  (inst_cnt)
  );

  // A store arriving while a byte is pending is dropped, including in the
  // cycle the transmitter accepts it.
  always_comb begin
    tx_valid_next = tx_valid_reg;
    tx_data_next  = tx_data_reg;
    if (tx_valid_reg) begin
      if (bus.tx_ready) begin
        tx_valid_next = 1'b0;
      end
    end else if (store_hit && (off == OFF_TX)) begin
      tx_valid_next = 1'b1;
      tx_data_next  = bus.req_wdata[7:0];
    end
  end

  // Draining and filling are exclusive: rx_ready is low whenever rx_full is set.
  always_comb begin
    rx_full_next = rx_full_reg;
    rx_byte_next = rx_byte_reg;
    if (load_hit && (off == OFF_RX) && rx_full_reg) begin
      rx_full_next = 1'b0;
    end
    if (bus.rx_valid && rx_ready) begin
      rx_full_next = 1'b1;
      rx_byte_next = bus.rx_data;
    end
  end

  always_comb begin
    rd_hit_next = load_hit;
    rdata_next  = rdata_reg;
    if (bus.req_re) begin
      rdata_next = 32'h0;
      if (hit) begin
        case (off)
          OFF_STATUS: rdata_next = {30'b0, rx_full_reg, !tx_valid_reg};
          OFF_RX:     rdata_next = {24'b0, rx_byte_reg};
          OFF_CYC:    rdata_next = 32'(cycle_cnt);
          OFF_INST:   rdata_next = 32'(inst_cnt);
          default:    rdata_next = 32'h0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg    <= 32'h0;
      rd_hit_reg   <= 1'b0;
      tx_data_reg  <= 8'h0;
      tx_valid_reg <= 1'b0;
      rx_byte_reg  <= 8'h0;
      rx_full_reg  <= 1'b0;
    end else begin
      rdata_reg    <= rdata_next;
      rd_hit_reg   <= rd_hit_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      rx_byte_reg  <= rx_byte_next;
      rx_full_reg  <= rx_full_next;
    end
  end

  assign bus.rdata    = rdata_reg;
  assign bus.rd_hit   = rd_hit_reg;
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_valid = tx_valid_reg;
  assign bus.rx_ready = rx_ready;

endmodule
